ist_mem_unit: RTL and testbench



---
 rtl/ist_pkg.sv | 53 +++++
 rtl/ist_trig_bram.sv | 28 ++
 rtl/ist_mem_unit.sv | 203 ++++++++++++++++++++
 tb/tb_ist_mem_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ist_pkg.sv
// Shared constants, payload structs and FSM encoding for the IST triangle fetch unit.
package ist_pkg;

  localparam int unsigned ID_WIDTH            = 5;
  localparam int unsigned NUM_CONCURRENT_RAYS = 1 << ID_WIDTH;
  localparam int unsigned ADDR_WIDTH          = 36;
  localparam int unsigned NUM_TRIGS_WIDTH     = 3;
  localparam int unsigned MAX_TRIGS_PER_NODE  = 7;
  localparam int unsigned TRIG_IDX_WIDTH      = 29;
  localparam int unsigned TRIG_BYTES          = 36;
  localparam int unsigned TRIG_WIDTH          = TRIG_BYTES * 8;
  localparam int unsigned AXI_DATA_WIDTH      = 512;
  localparam int unsigned LINE_SHIFT          = 6;
  localparam int unsigned LINE_WIDTH          = ADDR_WIDTH - LINE_SHIFT;
  localparam int unsigned MAX_LINES           = 5;
  localparam int unsigned BEAT_CNT_WIDTH      = 3;
  localparam int unsigned BUF_WIDTH           = MAX_LINES * AXI_DATA_WIDTH;
  localparam int unsigned BUF_IDX_WIDTH       = 12;
  localparam int unsigned BYTE_IDX_WIDTH      = 9;
  localparam int unsigned BRAM_DEPTH          = (MAX_TRIGS_PER_NODE - 1) * NUM_CONCURRENT_RAYS;
  localparam int unsigned BRAM_ADDR_WIDTH     = 8;
  localparam int unsigned REQ_WIDTH           = TRIG_IDX_WIDTH + NUM_TRIGS_WIDTH + ID_WIDTH;
  localparam int unsigned RESP_WIDTH          = TRIG_WIDTH + ID_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] TRIG_BASE_ADDR = 36'h8_4000_0000;
  localparam logic [2:0]            AXI_SIZE_64B   = 3'd6;
  localparam logic [1:0]            AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic [TRIG_IDX_WIDTH-1:0]  trig_idx;
    logic [NUM_TRIGS_WIDTH-1:0] num_trigs;
    logic [ID_WIDTH-1:0]        id;
  } req_t;

  typedef struct packed {
    logic [TRIG_WIDTH-1:0] trig;
    logic [ID_WIDTH-1:0]   id;
  } resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_WR,
    ST_RESP
  } state_t;

  // Byte address of a triangle: base + idx*36, built from shifts.
  function automatic logic [ADDR_WIDTH-1:0] trig_start(input logic [TRIG_IDX_WIDTH-1:0] idx);
    return TRIG_BASE_ADDR + (ADDR_WIDTH'(idx) << 5) + (ADDR_WIDTH'(idx) << 2);
  endfunction

endpackage

// File: rtl/ist_trig_bram.sv
// Simple dual-port per-ray triangle store: port A writes, port B reads with one cycle latency.
module ist_trig_bram
  import ist_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we_a,
  input  logic [BRAM_ADDR_WIDTH-1:0] addr_a,
  input  logic [TRIG_WIDTH-1:0]      din_a,
  input  logic                       en_b,
  input  logic [BRAM_ADDR_WIDTH-1:0] addr_b,
  output logic [TRIG_WIDTH-1:0]      dout_b
);

  logic [TRIG_WIDTH-1:0] mem [BRAM_DEPTH];

  // Contents are not reset; they survive aresetn.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
  end

  // Read-first on collision: the old word is sampled at the same edge as the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    dout_b <= '0;
    else if (en_b) dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/ist_mem_unit.sv
// IST triangle fetch: pops a request, reads the covering 64B lines over AXI, spills all but the
// last triangle into the per-ray BRAM and pushes the last triangle to the response FIFO.
module ist_mem_unit
  import ist_pkg::*;
(
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [REQ_WIDTH-1:0]       ist_mem_req_din,
  input  logic                       ist_mem_req_empty,
  output logic                       ist_mem_req_read,
  output logic [RESP_WIDTH-1:0]      ist_mem_resp_dout,
  input  logic                       ist_mem_resp_full,
  output logic                       ist_mem_resp_write,
  input  logic [BRAM_ADDR_WIDTH-1:0] addrb,
  input  logic                       enb,
  output logic [TRIG_WIDTH-1:0]      doutb,
  output logic [ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]  m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);

  state_t                       state_q, state_d;
  req_t                         req_q, req_d, req_in_c;
  resp_t                        resp_q, resp_d;
  logic [BEAT_CNT_WIDTH-1:0]    ar_cnt_q, ar_cnt_d, ar_next_c;
  logic [BEAT_CNT_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
  logic [NUM_TRIGS_WIDTH-1:0]   wr_k_q, wr_k_d, sel_k_c;
  logic                         arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0]        araddr_q, araddr_d;
  logic [2:0]                   arsize_q, arsize_d;
  logic [1:0]                   arburst_q, arburst_d;
  logic                         rready_q, rready_d;
  logic                         req_read_q, req_read_d;
  logic                         resp_write_q, resp_write_d;
  logic                         buf_we_c, bram_we_c;
  logic [BRAM_ADDR_WIDTH-1:0]   bram_addr_c;
  logic [ADDR_WIDTH-1:0]        start_c;
  logic [BYTE_IDX_WIDTH-1:0]    len_c, byte_base_c;
  logic [BUF_IDX_WIDTH-1:0]     bit_base_c;
  logic [BEAT_CNT_WIDTH-1:0]    nlines_c;
  logic [TRIG_WIDTH-1:0]        trig_c;
  logic [BUF_WIDTH-1:0]         buf_q;
  logic                         unused_r;

  assign req_in_c = req_t'(ist_mem_req_din);
  assign unused_r = ^{m_axi_rresp, m_axi_rlast};

  // Line geometry of the latched request.
  assign start_c   = trig_start(req_q.trig_idx);
  assign len_c     = BYTE_IDX_WIDTH'(req_q.num_trigs) * BYTE_IDX_WIDTH'(TRIG_BYTES);
  assign nlines_c  = BEAT_CNT_WIDTH'(((10'(start_c[LINE_SHIFT-1:0]) + 10'(len_c) - 10'd1) >> LINE_SHIFT)
                                     + 10'd1);
  assign ar_next_c = ar_cnt_q + BEAT_CNT_WIDTH'(1);

  // Triangle extraction from the assembly buffer: WR walks k, RESP takes the last one.
  assign sel_k_c     = (state_q == ST_WR) ? wr_k_q : (req_q.num_trigs - NUM_TRIGS_WIDTH'(1));
  assign byte_base_c = BYTE_IDX_WIDTH'(start_c[LINE_SHIFT-1:0])
                     + BYTE_IDX_WIDTH'(sel_k_c) * BYTE_IDX_WIDTH'(TRIG_BYTES);
  assign bit_base_c  = {byte_base_c, 3'b000};
  assign trig_c      = buf_q[bit_base_c +: TRIG_WIDTH];

  // Triangle k lands at slot (num_trigs-2-k) of this ray.
  assign bram_addr_c = {3'(req_q.num_trigs - NUM_TRIGS_WIDTH'(2) - wr_k_q), req_q.id};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      resp_q       <= '0;
      ar_cnt_q     <= '0;
      beat_cnt_q   <= '0;
      wr_k_q       <= '0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      rready_q     <= 1'b0;
      req_read_q   <= 1'b0;
      resp_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      resp_q       <= resp_d;
      ar_cnt_q     <= ar_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_k_q       <= wr_k_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      rready_q     <= rready_d;
      req_read_q   <= req_read_d;
      resp_write_q <= resp_write_d;
    end
  end

  // Beat n lands in bytes [64n, 64n+63] of the assembly buffer.
  always_ff @(posedge aclk) begin
    if (buf_we_c) buf_q[{beat_cnt_q, 9'd0} +: AXI_DATA_WIDTH] <= m_axi_rdata;
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    resp_d       = resp_q;
    ar_cnt_d     = ar_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    wr_k_d       = wr_k_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    rready_d     = rready_q;
    req_read_d   = 1'b0;
    resp_write_d = 1'b0;
    buf_we_c     = 1'b0;
    bram_we_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!ist_mem_req_empty) begin
          req_read_d = 1'b1;
          req_d      = req_in_c;
          if (req_in_c.num_trigs == '0) req_d.num_trigs = NUM_TRIGS_WIDTH'(1);
          ar_cnt_d   = '0;
          beat_cnt_d = '0;
          wr_k_d     = '0;
          state_d    = ST_AR;
        end
      end
      ST_AR: begin
        if (!arvalid_q) begin
          arvalid_d = 1'b1;
          araddr_d  = {start_c[ADDR_WIDTH-1:LINE_SHIFT] + LINE_WIDTH'(ar_cnt_q), 6'd0};
          arsize_d  = AXI_SIZE_64B;
          arburst_d = AXI_BURST_INCR;
        end else if (m_axi_arready) begin
          ar_cnt_d = ar_next_c;
          if (ar_next_c == nlines_c) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            state_d   = ST_R;
          end else begin
            araddr_d = {start_c[ADDR_WIDTH-1:LINE_SHIFT] + LINE_WIDTH'(ar_next_c), 6'd0};
          end
        end
      end
      ST_R: begin
        if (m_axi_rvalid && rready_q) begin
          buf_we_c   = 1'b1;
          beat_cnt_d = beat_cnt_q + BEAT_CNT_WIDTH'(1);
          if (beat_cnt_q + BEAT_CNT_WIDTH'(1) == nlines_c) begin
            rready_d = 1'b0;
            state_d  = (req_q.num_trigs == NUM_TRIGS_WIDTH'(1)) ? ST_RESP : ST_WR;
          end
        end
      end
      ST_WR: begin
        bram_we_c = 1'b1;
        wr_k_d    = wr_k_q + NUM_TRIGS_WIDTH'(1);
        if (wr_k_q == req_q.num_trigs - NUM_TRIGS_WIDTH'(2)) state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_d.trig = trig_c;
        resp_d.id   = req_q.id;
        if (!ist_mem_resp_full) begin
          resp_write_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  ist_trig_bram u_bram (
    .clk    (aclk),
    .rst_n  (aresetn),
    .we_a   (bram_we_c),
    .addr_a (bram_addr_c),
    .din_a  (trig_c),
    .en_b   (enb),
    .addr_b (addrb),
    .dout_b (doutb)
  );

  assign ist_mem_req_read   = req_read_q;
  assign ist_mem_resp_dout  = resp_q;
  assign ist_mem_resp_write = resp_write_q;
  assign m_axi_araddr       = araddr_q;
  assign m_axi_arlen        = 8'd0;
  assign m_axi_arsize       = arsize_q;
  assign m_axi_arburst      = arburst_q;
  assign m_axi_arvalid      = arvalid_q;
  assign m_axi_rready       = rready_q;

endmodule

// File: tb/tb_ist_mem_unit.sv
// Directed bench for ist_mem_unit with a byte-addressed DRAM model behind a randomly stalling AXI slave.
module tb_ist_mem_unit;
  import ist_pkg::*;

  logic                       aclk = 1'b0;
  logic                       aresetn;
  logic [REQ_WIDTH-1:0]       ist_mem_req_din;
  logic                       ist_mem_req_empty;
  logic                       ist_mem_req_read;
  logic [RESP_WIDTH-1:0]      ist_mem_resp_dout;
  logic                       ist_mem_resp_full;
  logic                       ist_mem_resp_write;
  logic [BRAM_ADDR_WIDTH-1:0] addrb;
  logic                       enb;
  logic [TRIG_WIDTH-1:0]      doutb;
  logic [ADDR_WIDTH-1:0]      m_axi_araddr;
  logic [7:0]                 m_axi_arlen;
  logic [2:0]                 m_axi_arsize;
  logic [1:0]                 m_axi_arburst;
  logic                       m_axi_arvalid;
  logic                       m_axi_arready = 1'b0;
  logic [AXI_DATA_WIDTH-1:0]  m_axi_rdata = '0;
  logic [1:0]                 m_axi_rresp = 2'b00;
  logic                       m_axi_rlast = 1'b0;
  logic                       m_axi_rvalid = 1'b0;
  logic                       m_axi_rready;

  int checks = 0;
  int errors = 0;

  logic [ADDR_WIDTH-1:0] rd_q[$];
  logic [ADDR_WIDTH-1:0] ar_log[$];
  logic                  ar_bad;
  logic                  r_acc = 1'b0;
  int                    gap = 0;

  always #5 aclk = ~aclk;

  ist_mem_unit dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .ist_mem_req_din    (ist_mem_req_din),
    .ist_mem_req_empty  (ist_mem_req_empty),
    .ist_mem_req_read   (ist_mem_req_read),
    .ist_mem_resp_dout  (ist_mem_resp_dout),
    .ist_mem_resp_full  (ist_mem_resp_full),
    .ist_mem_resp_write (ist_mem_resp_write),
    .addrb              (addrb),
    .enb                (enb),
    .doutb              (doutb),
    .m_axi_araddr       (m_axi_araddr),
    .m_axi_arlen        (m_axi_arlen),
    .m_axi_arsize       (m_axi_arsize),
    .m_axi_arburst      (m_axi_arburst),
    .m_axi_arvalid      (m_axi_arvalid),
    .m_axi_arready      (m_axi_arready),
    .m_axi_rdata        (m_axi_rdata),
    .m_axi_rresp        (m_axi_rresp),
    .m_axi_rlast        (m_axi_rlast),
    .m_axi_rvalid       (m_axi_rvalid),
    .m_axi_rready       (m_axi_rready)
  );

  function automatic logic [7:0] mem_byte(input logic [ADDR_WIDTH-1:0] a);
    logic [7:0] lo;
    lo = a[7:0] * 8'd37;
    return lo ^ a[15:8] ^ a[23:16] ^ {a[35:32], a[27:24]} ^ 8'h5A;
  endfunction

  function automatic logic [AXI_DATA_WIDTH-1:0] line_data(input logic [ADDR_WIDTH-1:0] a);
    logic [AXI_DATA_WIDTH-1:0] d;
    for (int b = 0; b < 64; b++) d[8*b +: 8] = mem_byte(a + ADDR_WIDTH'(b));
    return d;
  endfunction

  function automatic logic [TRIG_WIDTH-1:0] exp_trig(input logic [ADDR_WIDTH-1:0] start, input int k);
    logic [TRIG_WIDTH-1:0] t;
    for (int j = 0; j < 36; j++) t[8*j +: 8] = mem_byte(start + ADDR_WIDTH'(36*k + j));
    return t;
  endfunction

  // AXI slave: decisions at negedge; a handshake counts when both sides are high for the next posedge.
  always @(negedge aclk) begin
    if (!aresetn) begin
      rd_q.delete();
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_rlast   = 1'b0;
      r_acc         = 1'b0;
      gap           = 0;
    end else begin
      if (m_axi_rvalid && r_acc) begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        void'(rd_q.pop_front());
        gap = $urandom_range(0, 7);
      end
      if (!m_axi_rvalid) begin
        if (gap > 0) gap--;
        else if (rd_q.size() > 0) begin
          m_axi_rvalid = 1'b1;
          m_axi_rlast  = 1'b1;
          m_axi_rdata  = line_data(rd_q[0]);
        end
      end
      r_acc = m_axi_rvalid && m_axi_rready;
      m_axi_arready = 1'($urandom_range(0, 1));
      if (m_axi_arvalid && m_axi_arready) begin
        rd_q.push_back(m_axi_araddr);
        ar_log.push_back(m_axi_araddr);
        if (m_axi_arlen != 8'd0 || m_axi_arsize != 3'd6 || m_axi_arburst != 2'b01) ar_bad = 1'b1;
      end
    end
  end

  task automatic run_txn(input logic [28:0] idx, input logic [2:0] num, input logic [4:0] id);
    logic [ADDR_WIDTH-1:0] start;
    logic [RESP_WIDTH-1:0] got;
    logic                  order_ok;
    int n_eff, nl, reads, writes, cyc;
    n_eff = (num == 3'd0) ? 1 : int'(num);
    start = TRIG_BASE_ADDR + ADDR_WIDTH'(idx) * 36'd36;
    nl = int'(((start + ADDR_WIDTH'(n_eff * 36) - 36'd1) >> 6) - (start >> 6)) + 1;
    ar_log.delete();
    ar_bad = 1'b0;
    got = '0;
    ist_mem_req_din   = {idx, num, id};
    ist_mem_req_empty = 1'b0;
    reads = 0; writes = 0; cyc = 0;
    while (writes == 0 && cyc < 1000) begin
      @(negedge aclk);
      cyc++;
      if (ist_mem_req_read) begin reads++; ist_mem_req_empty = 1'b1; end
      if (ist_mem_resp_write) begin writes++; got = ist_mem_resp_dout; end
    end
    ist_mem_req_empty = 1'b1;
    checks++;
    if (writes !== 1) begin
      errors++;
      $display("FAIL txn_timeout idx=%0d num=%0d: resp writes %0d want 1", idx, num, writes);
    end
    @(negedge aclk);
    checks++;
    if (ist_mem_resp_write !== 1'b0) begin
      errors++; $display("FAIL resp_pulse idx=%0d num=%0d: resp_write %b want 0", idx, num, ist_mem_resp_write);
    end
    checks++;
    if (reads !== 1) begin
      errors++; $display("FAIL req_read_pulses idx=%0d num=%0d: got %0d want 1", idx, num, reads);
    end
    checks++;
    if (got[4:0] !== id) begin
      errors++; $display("FAIL resp_id idx=%0d num=%0d: got %0d want %0d", idx, num, got[4:0], id);
    end
    checks++;
    if (got[292:5] !== exp_trig(start, n_eff - 1)) begin
      errors++; $display("FAIL resp_trig idx=%0d num=%0d: got %h want %h", idx, num, got[292:5], exp_trig(start, n_eff - 1));
    end
    order_ok = (ar_log.size() == nl) && !ar_bad;
    for (int i = 0; i < ar_log.size(); i++)
      if (ar_log[i] !== {start[35:6] + 30'(i), 6'd0}) order_ok = 1'b0;
    checks++;
    if (order_ok !== 1'b1) begin
      errors++; $display("FAIL ar_lines idx=%0d num=%0d: %0d ARs (bad=%b) want %0d ascending from %h", idx, num, ar_log.size(), ar_bad, nl, {start[35:6], 6'd0});
    end
    for (int k = 0; k < n_eff - 1; k++) begin
      addrb = 8'((n_eff - 2 - k) * 32 + int'(id));
      enb   = 1'b1;
      @(negedge aclk);
      enb   = 1'b0;
      checks++;
      if (doutb !== exp_trig(start, k)) begin
        errors++; $display("FAIL bram_slot idx=%0d num=%0d k=%0d: got %h want %h", idx, num, k, doutb, exp_trig(start, k));
      end
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (100) @(negedge aclk);
    checks++;
    if ({ist_mem_req_read, ist_mem_resp_write, m_axi_arvalid, m_axi_rready} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: req_read/resp_write/arvalid/rready=%b want 0000", {ist_mem_req_read, ist_mem_resp_write, m_axi_arvalid, m_axi_rready});
    end
    checks++;
    if (ist_mem_resp_dout !== '0 || m_axi_araddr !== '0 || doutb !== '0) begin
      errors++; $display("FAIL reset_data: resp_dout/araddr/doutb not zero (araddr=%h)", m_axi_araddr);
    end
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_single();
    run_txn(29'd0, 3'd1, 5'd5);
    checks++;
    if (ar_log.size() !== 1 || ar_log[0] !== 36'h8_4000_0000) begin
      errors++; $display("FAIL single_ar: %0d ARs first %h want 1 at 840000000", ar_log.size(), ar_log[0]);
    end
  endtask

  task automatic test_seven();
    run_txn(29'd3, 3'd7, 5'd31);
    checks++;
    if (ar_log.size() !== 5 || ar_log[0] !== 36'h8_4000_0040 || ar_log[4] !== 36'h8_4000_0140) begin
      errors++; $display("FAIL seven_ar: %0d ARs first %h last %h want 5 from 840000040 to 840000140", ar_log.size(), ar_log[0], ar_log[ar_log.size()-1]);
    end
  endtask

  task automatic test_sweep();
    logic [28:0] idx;
    for (int i = 0; i < 19; i++) begin
      if (i < 16)       idx = 29'(i);
      else if (i == 16) idx = 29'd2041;
      else if (i == 17) idx = 29'h1FFF_FFF0;
      else              idx = 29'h1FFF_FFFF;
      for (int n = 1; n <= 7; n++) run_txn(idx, 3'(n), 5'($urandom_range(0, 31)));
    end
  endtask

  task automatic test_num_zero();
    run_txn(29'd9, 3'd0, 5'd17);
    checks++;
    if (ar_log.size() !== 1 || ar_log[0] !== 36'h8_4000_0140) begin
      errors++; $display("FAIL num_zero_ar: %0d ARs first %h want 1 at 840000140", ar_log.size(), ar_log[0]);
    end
  endtask

  task automatic test_resp_full();
    logic [ADDR_WIDTH-1:0] start;
    logic [RESP_WIDTH-1:0] exp;
    int writes;
    start = TRIG_BASE_ADDR + 36'd36 * 36'd5;
    exp   = {exp_trig(start, 3), 5'd12};
    ist_mem_resp_full = 1'b1;
    ist_mem_req_din   = {29'd5, 3'd4, 5'd12};
    ist_mem_req_empty = 1'b0;
    writes = 0;
    repeat (200) begin
      @(negedge aclk);
      if (ist_mem_req_read) ist_mem_req_empty = 1'b1;
      if (ist_mem_resp_write) writes++;
    end
    ist_mem_req_empty = 1'b1;
    checks++;
    if (ist_mem_resp_dout !== exp) begin
      errors++; $display("FAIL full_dout: got %h want %h", ist_mem_resp_dout, exp);
    end
    repeat (20) begin
      @(negedge aclk);
      if (ist_mem_resp_write) writes++;
    end
    checks++;
    if (writes !== 0 || ist_mem_resp_dout !== exp) begin
      errors++; $display("FAIL full_hold: writes %0d want 0, dout %h want %h", writes, ist_mem_resp_dout, exp);
    end
    ist_mem_resp_full = 1'b0;
    repeat (10) begin
      @(negedge aclk);
      if (ist_mem_resp_write) writes++;
    end
    checks++;
    if (writes !== 1 || ist_mem_resp_dout !== exp) begin
      errors++; $display("FAIL full_release: writes %0d want 1, dout %h want %h", writes, ist_mem_resp_dout, exp);
    end
  endtask

  task automatic test_reset_mid_r();
    int cyc;
    ist_mem_req_din   = {29'd3, 3'd7, 5'd2};
    ist_mem_req_empty = 1'b0;
    cyc = 0;
    while (!m_axi_rready && cyc < 300) begin
      @(negedge aclk);
      cyc++;
      if (ist_mem_req_read) ist_mem_req_empty = 1'b1;
    end
    ist_mem_req_empty = 1'b1;
    checks++;
    if (m_axi_rready !== 1'b1) begin
      errors++; $display("FAIL mid_r_reach: rready %b want 1", m_axi_rready);
    end
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    checks++;
    if ({m_axi_rready, m_axi_arvalid, ist_mem_resp_write, ist_mem_req_read} !== 4'b0000) begin
      errors++; $display("FAIL mid_r_reset: rready/arvalid/resp_write/req_read=%b want 0000", {m_axi_rready, m_axi_arvalid, ist_mem_resp_write, ist_mem_req_read});
    end
    repeat (5) @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    checks++;
    if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0) begin
      errors++; $display("FAIL mid_r_idle: arvalid %b rready %b want 0 0", m_axi_arvalid, m_axi_rready);
    end
    run_txn(29'd10, 3'd5, 5'd9);
  endtask

  initial begin
    aresetn           = 1'b0;
    ist_mem_req_din   = '0;
    ist_mem_req_empty = 1'b1;
    ist_mem_resp_full = 1'b0;
    addrb             = '0;
    enb               = 1'b0;
    ar_bad            = 1'b0;
    test_reset();
    test_single();
    test_seven();
    test_num_zero();
    test_sweep();
    test_resp_full();
    test_reset_mid_r();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
